// File: rtl/sdram_slot_arbiter.sv
// Slot-timed arbiter in front of the SDRAM controller: generates the 8-clock
// slot strobe, picks one of three clients per slot and returns acks/read data.
module sdram_slot_arbiter #(
    parameter int INIT_SLOTS  = 40,
    parameter int REFRESH_MAX = 64,
    parameter int STARVE_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic        vid_ack,

    input  logic        cpu_req,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,

    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic        dma_we,
    input  logic [1:0]  dma_ds,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,

    output logic [15:0] rd_data,

    output logic        sync,
    output logic        sd_oe,
    output logic        sd_we,
    output logic [23:0] sd_addr,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_din,
    input  logic [15:0] sd_dout
);

    localparam int INIT_W   = $clog2(INIT_SLOTS + 1);
    localparam int BUSY_W   = $clog2(REFRESH_MAX + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_VID  = 2'd1,
        PORT_CPU  = 2'd2,
        PORT_DMA  = 2'd3
    } port_t;

    logic [2:0]          slot_cnt;
    logic [2:0]          slot_nxt;
    logic                decide;
    logic [INIT_W-1:0]   init_cnt;
    logic [BUSY_W-1:0]   busy_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    port_t               inflight;
    port_t               winner;

    logic                hold_off;
    logic                dma_promoted;
    logic                vid_elig;
    logic                cpu_elig;
    logic                dma_elig;

    logic [23:0]         win_addr;
    logic [1:0]          win_ds;
    logic [15:0]         win_din;
    logic                win_we;

    assign slot_nxt = slot_cnt + 3'd1;
    assign decide   = (slot_cnt == 3'd7);

    // sync is high for slot cycles 0..3, i.e. whenever bit 2 of the count is clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= 3'd0;
            sync     <= 1'b0;
        end else begin
            slot_cnt <= slot_nxt;
            sync     <= ~slot_nxt[2];
        end
    end

    always_comb begin
        hold_off     = (init_cnt != '0) || (busy_cnt == BUSY_W'(REFRESH_MAX));
        dma_promoted = (starve_cnt == STARVE_W'(STARVE_MAX));
        vid_elig     = vid_req && (inflight != PORT_VID) && !hold_off;
        cpu_elig     = cpu_req && (inflight != PORT_CPU) && !hold_off;
        dma_elig     = dma_req && (inflight != PORT_DMA) && !hold_off;

        winner = PORT_NONE;
        if (vid_elig)
            winner = PORT_VID;
        else if (dma_promoted && dma_elig)
            winner = PORT_DMA;
        else if (cpu_elig)
            winner = PORT_CPU;
        else if (dma_elig)
            winner = PORT_DMA;
    end

    // Video has no write data; it leaves sd_din untouched.
    always_comb begin
        win_addr = sd_addr;
        win_ds   = sd_ds;
        win_din  = sd_din;
        win_we   = 1'b0;
        case (winner)
            PORT_VID: begin
                win_addr = vid_addr;
                win_ds   = 2'b11;
            end
            PORT_CPU: begin
                win_addr = cpu_addr;
                win_ds   = cpu_ds;
                win_din  = cpu_wdata;
                win_we   = cpu_we;
            end
            PORT_DMA: begin
                win_addr = dma_addr;
                win_ds   = dma_ds;
                win_din  = dma_wdata;
                win_we   = dma_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_oe    <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= 24'd0;
            sd_ds    <= 2'd0;
            sd_din   <= 16'd0;
            inflight <= PORT_NONE;
        end else if (decide) begin
            inflight <= winner;
            if (winner == PORT_NONE) begin
                sd_oe <= 1'b0;
                sd_we <= 1'b0;
            end else begin
                sd_oe   <= ~win_we;
                sd_we   <= win_we;
                sd_addr <= win_addr;
                sd_ds   <= win_ds;
                sd_din  <= win_din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt   <= INIT_W'(INIT_SLOTS);
            busy_cnt   <= '0;
            starve_cnt <= '0;
        end else if (decide) begin
            if (init_cnt != '0)
                init_cnt <= init_cnt - 1'b1;

            if (winner == PORT_NONE)
                busy_cnt <= '0;
            else
                busy_cnt <= busy_cnt + 1'b1;

            if (winner == PORT_DMA)
                starve_cnt <= '0;
            else if (winner == PORT_CPU && dma_elig && !dma_promoted)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // The decision edge also closes the previous slot: ack it and capture read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            rd_data <= 16'd0;
        end else begin
            vid_ack <= decide && (inflight == PORT_VID);
            cpu_ack <= decide && (inflight == PORT_CPU);
            dma_ack <= decide && (inflight == PORT_DMA);
            if (decide && sd_oe)
                rd_data <= sd_dout;
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Randomized bench for sdram_slot_arbiter against a slot-level reference model.
module tb_sdram_slot_arbiter;

    localparam int INIT_SLOTS  = 40;
    localparam int REFRESH_MAX = 64;
    localparam int STARVE_MAX  = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req, cpu_req, dma_req;
    logic [23:0] vid_addr, cpu_addr, dma_addr;
    logic        cpu_we, dma_we;
    logic [1:0]  cpu_ds, dma_ds;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        vid_ack, cpu_ack, dma_ack;
    logic [15:0] rd_data;
    logic        sync, sd_oe, sd_we;
    logic [23:0] sd_addr;
    logic [1:0]  sd_ds;
    logic [15:0] sd_din;
    logic [15:0] sd_dout;

    // client index: 0 = video, 1 = cpu, 2 = dma
    logic        req  [3];
    logic [23:0] addr [3];
    logic        we   [3];
    logic [1:0]  ds   [3];
    logic [15:0] wd   [3];

    assign vid_req   = req[0];
    assign vid_addr  = addr[0];
    assign cpu_req   = req[1];
    assign cpu_addr  = addr[1];
    assign cpu_we    = we[1];
    assign cpu_ds    = ds[1];
    assign cpu_wdata = wd[1];
    assign dma_req   = req[2];
    assign dma_addr  = addr[2];
    assign dma_we    = we[2];
    assign dma_ds    = ds[2];
    assign dma_wdata = wd[2];

    always #5 clk = ~clk;

    sdram_slot_arbiter #(
        .INIT_SLOTS (INIT_SLOTS),
        .REFRESH_MAX(REFRESH_MAX),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_ds   (cpu_ds),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_we   (dma_we),
        .dma_ds   (dma_ds),
        .dma_wdata(dma_wdata),
        .dma_ack  (dma_ack),
        .rd_data  (rd_data),
        .sync     (sync),
        .sd_oe    (sd_oe),
        .sd_we    (sd_we),
        .sd_addr  (sd_addr),
        .sd_ds    (sd_ds),
        .sd_din   (sd_din),
        .sd_dout  (sd_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // reference model: slot position, counters of the slot rules, expected outputs
    int          m_pos, m_init, m_busy, m_starve, m_inflight;
    logic        m_decision;
    logic        exp_sync, exp_oe, exp_we;
    logic [23:0] exp_addr;
    logic [1:0]  exp_ds;
    logic [15:0] exp_din, exp_rd;
    logic [2:0]  exp_ack;

    int load_pct;
    int new_pct;
    bit withdraw_en;

    task automatic model_reset();
        m_pos      = 0;
        m_init     = INIT_SLOTS;
        m_busy     = 0;
        m_starve   = 0;
        m_inflight = -1;
        m_decision = 1'b0;
        exp_sync   = 1'b0;
        exp_oe     = 1'b0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_ds     = '0;
        exp_din    = '0;
        exp_rd     = '0;
        exp_ack    = '0;
    endtask

    task automatic model_edge();
        int win;
        int order [3];
        exp_ack    = '0;
        m_decision = (m_pos == 7);
        if (m_decision) begin
            if (m_inflight >= 0) begin
                exp_ack[m_inflight] = 1'b1;
                if (exp_oe)
                    exp_rd = sd_dout;
            end
            win = -1;
            if (m_init == 0 && m_busy < REFRESH_MAX) begin
                if (m_starve >= STARVE_MAX) order = '{0, 2, 1};
                else                        order = '{0, 1, 2};
                for (int k = 0; k < 3; k++)
                    if (win < 0 && req[order[k]] && order[k] != m_inflight)
                        win = order[k];
            end
            if (win < 0) begin
                exp_oe = 1'b0;
                exp_we = 1'b0;
                m_busy = 0;
            end else begin
                exp_we   = (win == 0) ? 1'b0 : we[win];
                exp_oe   = ~exp_we;
                exp_addr = addr[win];
                exp_ds   = (win == 0) ? 2'b11 : ds[win];
                if (win != 0)
                    exp_din = wd[win];
                m_busy++;
            end
            if (win == 2)
                m_starve = 0;
            else if (win == 1 && req[2] && m_inflight != 2 && m_starve < STARVE_MAX)
                m_starve++;
            if (m_init > 0)
                m_init--;
            m_inflight = win;
        end
        m_pos    = (m_pos + 1) % 8;
        exp_sync = (m_pos < 4);
    endtask

    task automatic compare_outputs();
        check_eq("sync",    32'(sync),    32'(exp_sync));
        check_eq("sd_oe",   32'(sd_oe),   32'(exp_oe));
        check_eq("sd_we",   32'(sd_we),   32'(exp_we));
        check_eq("sd_addr", 32'(sd_addr), 32'(exp_addr));
        check_eq("sd_ds",   32'(sd_ds),   32'(exp_ds));
        check_eq("sd_din",  32'(sd_din),  32'(exp_din));
        check_eq("acks",    32'({dma_ack, cpu_ack, vid_ack}), 32'(exp_ack));
        check_eq("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic new_request(input int p);
        req[p]  = 1'b1;
        addr[p] = 24'($urandom);
        we[p]   = (p == 0) ? 1'b0 : 1'($urandom);
        ds[p]   = (p == 0) ? 2'b11 : 2'($urandom_range(3, 1));
        wd[p]   = 16'($urandom);
    endtask

    task automatic update_clients();
        logic [2:0] ack_seen;
        ack_seen = {dma_ack, cpu_ack, vid_ack};
        for (int p = 0; p < 3; p++) begin
            if (ack_seen[p]) begin
                if ($urandom_range(99) < new_pct) new_request(p);
                else                              req[p] = 1'b0;
            end else if (!req[p]) begin
                if ($urandom_range(99) < load_pct) new_request(p);
            end else if (withdraw_en && $urandom_range(299) == 0) begin
                req[p] = 1'b0;
            end
        end
        sd_dout = 16'($urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
        @(negedge clk);
        update_clients();
    endtask

    task automatic apply_reset(input int clocks);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        for (int i = 0; i < clocks; i++) begin
            @(posedge clk);
            #1;
            compare_outputs();
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int  idle_decisions;
    bit  granted;
    bit  found;

    initial begin
        for (int p = 0; p < 3; p++) begin
            req[p]  = 1'b0;
            addr[p] = '0;
            we[p]   = 1'b0;
            ds[p]   = 2'b11;
            wd[p]   = '0;
        end
        sd_dout     = '0;
        load_pct    = 100;
        new_pct     = 50;
        withdraw_en = 1'b0;
        reset_n     = 1'b1;
        #2;
        apply_reset(3);

        // init hold-off with every client requesting
        for (int p = 0; p < 3; p++)
            new_request(p);
        idle_decisions = 0;
        granted        = 1'b0;
        for (int n = 0; n < 45 * 8; n++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_outputs();
            if (m_decision && !granted) begin
                if (!sd_oe && !sd_we) begin
                    idle_decisions++;
                end else begin
                    granted = 1'b1;
                    check_eq("first_grant_ds",   32'(sd_ds),   32'(2'b11));
                    check_eq("first_grant_addr", 32'(sd_addr), 32'(addr[0]));
                end
            end
            @(negedge clk);
            update_clients();
        end
        check_eq("init_idle_slots", 32'(idle_decisions), 32'(INIT_SLOTS));
        check_eq("init_granted",    32'(granted),        32'd1);

        // heavy contention: refresh forcing and DMA starvation promotion
        load_pct    = 95;
        new_pct     = 40;
        withdraw_en = 1'b1;
        for (int n = 0; n < 2400; n++)
            cycle();

        // light, sparse traffic
        load_pct = 10;
        new_pct  = 10;
        for (int n = 0; n < 1200; n++)
            cycle();

        // reset in slot cycle 4 of a DMA read
        load_pct = 95;
        new_pct  = 40;
        found    = 1'b0;
        for (int n = 0; n < 6000 && !found; n++) begin
            cycle();
            if (m_pos == 4 && m_inflight == 2 && exp_oe)
                found = 1'b1;
        end
        check_eq("mid_reset_dma_read_seen", 32'(found), 32'd1);
        apply_reset(2);
        check_eq("mid_reset_no_dma_ack", 32'(dma_ack), 32'd0);
        for (int n = 0; n < 45 * 8 + 800; n++)
            cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
